// File: rtl/score_disp_pkg.sv
// Shared constants, FSM state type and active-low gfedcba segment decode for score_display.
package score_disp_pkg;
    localparam int SCORE_W_DEF = 11;
    localparam int NUM_DIGITS  = 4;
    localparam int BCD_W       = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IDLE -> SHIFT (SCORE_W cycles) -> DONE.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] bin,
    input  logic               start,
    output logic [BCD_W-1:0]   bcd,
    output logic               done,
    output logic               busy
);
    state_t             r_state;
    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [3:0]         r_iter;
    logic               r_busy;
    logic [BCD_W-1:0]   w_adj;

    // Add-3 correction is applied before the shift on every nibble >= 5.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_bin   <= bin;
                    r_bcd   <= '0;
                    r_iter  <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_bcd  <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
                    r_bin  <= {r_bin[SCORE_W-2:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'(SCORE_W - 1))
                        r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign done = (r_state == DONE);
    assign busy = r_busy;
endmodule

// File: rtl/score_display.sv
// Binary score -> BCD -> multiplexed 4-digit common-anode display.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module score_display
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               busy
);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [SCORE_W-1:0] r_last_score;
    logic [BCD_W-1:0]   r_bcd_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_start;
    logic               w_done;
    logic               w_busy;
    logic [BCD_W-1:0]   w_bcd;
    logic [3:0]         w_nib;
    logic               w_blank;

    // The converter is only idle when busy is low, so a change seen while busy waits here.
    assign w_start = (score != r_last_score) && !w_busy;

    bin2bcd_seq #(.SCORE_W(SCORE_W)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (score),
        .start (w_start),
        .bcd   (w_bcd),
        .done  (w_done),
        .busy  (w_busy)
    );

    assign w_nib = r_bcd_q[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (r_idx != 2'd0) && ((r_bcd_q >> {r_idx, 2'b00}) == '0);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_score <= '0;
            r_bcd_q      <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_an         <= 4'b1111;
            r_seg        <= SEG_BLANK;
        end else begin
            if (w_start)
                r_last_score <= score;
            // Only the finished scratch value is copied, so partial conversions never show.
            if (w_done)
                r_bcd_q <= w_bcd;
            if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? SEG_BLANK : seg_decode(w_nib);
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign busy = w_busy;
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: conversion latency, displayed digits, busy handling, reset abort.
module tb_score_display;
    localparam int SCAN_DIV = 4;
    localparam int SCORE_W  = 11;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [SCORE_W-1:0] score = '0;
    logic [3:0]         an;
    logic [6:0]         seg;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [SCORE_W-1:0] score;
        logic [15:0]        bcd;
    } vec_t;

    vec_t       vecs[8];
    logic [6:0] tseg[10];
    int         pow10[4];

    always #5 clk = ~clk;

    score_display #(.SCAN_DIV(SCAN_DIV), .SCORE_W(SCORE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .an    (an),
        .seg   (seg),
        .busy  (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int value, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && value < pow10[d]) return 7'h7f;
`endif
        return tseg[(value / pow10[d]) % 10];
    endfunction

    // Call right after the input change that should start a conversion.
    task automatic conv_check(input string name, input logic [15:0] exp_bcd);
        int k;
        k = 0;
        tick(1);
        while (busy === 1'b1 && k < 40) begin
            k++;
            tick(1);
        end
        chk({name, "_busy_cycles"}, k, 12);
        chk({name, "_bcd_q"}, dut.r_bcd_q, exp_bcd);
    endtask

    task automatic disp_check(input string name, input int value);
        logic [6:0] got[4];
        int bad;
        bad = 0;
        for (int d = 0; d < 4; d++) got[d] = 7'h55;
        tick(1);
        for (int i = 0; i < 8 * SCAN_DIV; i++) begin
            tick(1);
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: bad++;
            endcase
        end
        chk({name, "_an_onehot"}, bad, 0);
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s_digit%0d", name, d), got[d], exp_seg(value, d));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bh;
        int bad;
        logic seen9;

        tseg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        pow10 = '{1, 10, 100, 1000};
        vecs[0] = '{11'd2047, 16'h2047};
        vecs[1] = '{11'd0,    16'h0000};
        vecs[2] = '{11'd205,  16'h0205};
        vecs[3] = '{11'd7,    16'h0007};
        vecs[4] = '{11'd1000, 16'h1000};
        vecs[5] = '{11'd10,   16'h0010};
        vecs[6] = '{11'd999,  16'h0999};
        vecs[7] = '{11'd5,    16'h0005};

        // Reset held with score 0
        reset = 1'b0;
        score = '0;
        tick(3);
        chk("rst_an", an, 4'hf);
        chk("rst_seg", seg, 7'h7f);
        chk("rst_busy", busy, 0);
        chk("rst_bcd_q", dut.r_bcd_q, 0);
        reset = 1'b1;
        bh = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy !== 1'b0) bh++;
        end
        chk("zero_no_busy", bh, 0);
        disp_check("zero", 0);

        // 0 -> 123, then scan order units -> tens
        score = 11'd123;
        conv_check("s123", 16'h0123);
        k = 0;
        while (an !== 4'b1101 && k < 40) begin tick(1); k++; end
        while (an !== 4'b1110 && k < 40) begin tick(1); k++; end
        chk("scan_wait", (k < 40), 1);
        chk("scan_units_seg", seg, tseg[3]);
        tick(SCAN_DIV);
        chk("scan_tens_an", an, 4'b1101);
        chk("scan_tens_seg", seg, tseg[2]);
        disp_check("s123", 123);

        for (int i = 0; i < 8; i++) begin
            score = vecs[i].score;
            conv_check($sformatf("vec%0d", i), vecs[i].bcd);
            disp_check($sformatf("vec%0d", i), int'(vecs[i].score));
        end

        // 5 -> 9, then 9 -> 11 while the 9 conversion is running
        score = 11'd9;
        tick(3);
        score = 11'd11;
        bad = 0;
        seen9 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (dut.r_bcd_q == 16'h0009) seen9 = 1'b1;
            else if (dut.r_bcd_q != 16'h0005 && dut.r_bcd_q != 16'h0011) bad++;
        end
        chk("busy_seq_no_mixed", bad, 0);
        chk("busy_seq_seen9", seen9, 1);
        chk("busy_seq_final", dut.r_bcd_q, 16'h0011);
        chk("busy_seq_idle", busy, 0);
        disp_check("s11", 11);

        // Reset during the 6th SHIFT cycle of 999
        score = 11'd999;
        tick(1);
        tick(5);
        chk("abort_was_busy", busy, 1);
        reset = 1'b0;
        tick(1);
        chk("abort_bcd_q", dut.r_bcd_q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_an", an, 4'hf);
        chk("abort_seg", seg, 7'h7f);
        reset = 1'b1;
        conv_check("rst999", 16'h0999);
        disp_check("rst999", 999);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
